// File: rtl/jtframe_sdram_share.sv
// jtframe_sdram_share: arbitrates one SDRAM bank port between the game
// (requester 0, default priority) and an auxiliary master (requester 1).
// An 8-bit starvation counter forces an aux grant after STARVE game grants
// made while aux was waiting.
// Optional feature macro: JTFRAME_SHARE_TIMEOUT_EN adds a 10-bit watchdog
// that abandons a transfer after 1023 busy cycles without ba_rdy and sets a
// sticky timeout flag. Without it the block waits for ba_rdy forever and
// timeout is tied low.
module jtframe_sdram_share #(
  parameter int AW     = 22,
  parameter int STARVE = 8
) (
  input  logic          clk,
  input  logic          rst,
  // game requester
  input  logic [AW-1:0] rq0_addr,
  input  logic          rq0_rd,
  input  logic          rq0_wr,
  input  logic [15:0]   rq0_din,
  input  logic [1:0]    rq0_din_m,
  output logic          rq0_ack,
  output logic          rq0_dst,
  output logic          rq0_rdy,
  // auxiliary requester
  input  logic [AW-1:0] rq1_addr,
  input  logic          rq1_rd,
  input  logic          rq1_wr,
  input  logic [15:0]   rq1_din,
  input  logic [1:0]    rq1_din_m,
  output logic          rq1_ack,
  output logic          rq1_dst,
  output logic          rq1_rdy,
  // SDRAM controller bank port
  output logic [AW-1:0] ba_addr,
  output logic          ba_rd,
  output logic          ba_wr,
  output logic [15:0]   ba_din,
  output logic [1:0]    ba_din_m,
  input  logic          ba_ack,
  input  logic          ba_dst,
  input  logic          ba_rdy,
  // status
  output logic          owner,
  output logic          busy,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d;

  logic req0;
  logic req1;
  logic starved;
  logic tmo_fire;   // watchdog abandons the current transfer this cycle

  assign req0    = rq0_rd | rq0_wr;
  assign req1    = rq1_rd | rq1_wr;
  assign starved = (cnt_q >= STARVE_LIM);

`ifdef JTFRAME_SHARE_TIMEOUT_EN
  logic [9:0] timer_q, timer_d;
  logic       timeout_q, timeout_d;

  // Watchdog: held at zero while idle (so it is zero on entry to BUSYx),
  // counts busy cycles, fires when it has reached 1023 without ba_rdy.
  always_comb begin
    timer_d   = timer_q;
    timeout_d = timeout_q;
    tmo_fire  = 1'b0;
    if (state_q == IDLE) begin
      timer_d = 10'd0;
    end else begin
      timer_d = timer_q + 10'd1;
      if ((timer_q == 10'd1023) && !ba_rdy) begin
        tmo_fire  = 1'b1;
        timeout_d = 1'b1;
      end
    end
  end

  // Watchdog registers; the timeout flag is sticky until rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= 10'd0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Grant decision and transfer completion; starvation counter bookkeeping.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req1 && starved) begin
          state_d = BUSY1;
          owner_d = 1'b1;
          cnt_d   = 8'd0;
        end else if (req0) begin
          state_d = BUSY0;
          owner_d = 1'b0;
          // only count game grants that made aux wait
          if (req1 && (cnt_q != 8'hff)) begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (req1) begin
          state_d = BUSY1;
          owner_d = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      BUSY0, BUSY1: begin
        // always pass through IDLE so there is a gap between transfers
        if (ba_rdy || tmo_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

  // Request bundle mux: owner equals the grantee while busy; in IDLE the
  // data path just keeps following the last grantee.
  assign ba_addr  = owner_q ? rq1_addr  : rq0_addr;
  assign ba_din   = owner_q ? rq1_din   : rq0_din;
  assign ba_din_m = owner_q ? rq1_din_m : rq0_din_m;
  assign ba_rd    = busy && !tmo_fire && (owner_q ? rq1_rd : rq0_rd);
  assign ba_wr    = busy && !tmo_fire && (owner_q ? rq1_wr : rq0_wr);

  // Handshake return path: unregistered, only the grantee sees the strobes.
  logic [1:0] grant;
  logic [1:0] ack_v;
  logic [1:0] dst_v;
  logic [1:0] rdy_v;

  assign grant = {state_q == BUSY1, state_q == BUSY0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_route
      assign ack_v[gi] = grant[gi] & ba_ack;
      assign dst_v[gi] = grant[gi] & ba_dst;
      assign rdy_v[gi] = grant[gi] & ba_rdy;
    end
  endgenerate

  assign rq0_ack = ack_v[0];
  assign rq0_dst = dst_v[0];
  assign rq0_rdy = rdy_v[0];
  assign rq1_ack = ack_v[1];
  assign rq1_dst = dst_v[1];
  assign rq1_rdy = rdy_v[1];

endmodule

// File: tb/tb_jtframe_sdram_share.sv
// Bench for jtframe_sdram_share: cycle table for the basic handshakes,
// hand sequences for starvation, routing isolation, async reset and the
// optional watchdog, then random traffic against a grant-policy model.
module tb_jtframe_sdram_share;
  localparam int AW     = 22;
  localparam int STARVE = 8;
  localparam logic [AW-1:0] A0 = 22'h011111;
  localparam logic [AW-1:0] A1 = 22'h2a2a2a;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rq0_addr, rq1_addr, ba_addr;
  logic          rq0_rd, rq0_wr, rq1_rd, rq1_wr;
  logic [15:0]   rq0_din, rq1_din, ba_din;
  logic [1:0]    rq0_din_m, rq1_din_m, ba_din_m;
  logic          rq0_ack, rq0_dst, rq0_rdy;
  logic          rq1_ack, rq1_dst, rq1_rdy;
  logic          ba_rd, ba_wr, ba_ack, ba_dst, ba_rdy;
  logic          owner, busy, timeout;

  always #5 clk = ~clk;

  jtframe_sdram_share #(.AW(AW), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .rq0_addr(rq0_addr), .rq0_rd(rq0_rd), .rq0_wr(rq0_wr), .rq0_din(rq0_din),
    .rq0_din_m(rq0_din_m), .rq0_ack(rq0_ack), .rq0_dst(rq0_dst), .rq0_rdy(rq0_rdy),
    .rq1_addr(rq1_addr), .rq1_rd(rq1_rd), .rq1_wr(rq1_wr), .rq1_din(rq1_din),
    .rq1_din_m(rq1_din_m), .rq1_ack(rq1_ack), .rq1_dst(rq1_dst), .rq1_rdy(rq1_rdy),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din),
    .ba_din_m(ba_din_m), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy),
    .owner(owner), .busy(busy), .timeout(timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // one cycle of stimulus and the outputs expected in that cycle
  typedef struct {
    logic [6:0] in;  // {rq0_rd, rq0_wr, rq1_rd, rq1_wr, ba_ack, ba_dst, ba_rdy}
    logic [3:0] eo;  // {ba_rd, ba_wr, owner, busy}
    logic [2:0] e0;  // {rq0_ack, rq0_dst, rq0_rdy}
    logic [2:0] e1;  // {rq1_ack, rq1_dst, rq1_rdy}
  } vec_t;
  vec_t vt [18];

  task automatic idle_inputs();
    rq0_rd = 0; rq0_wr = 0; rq1_rd = 0; rq1_wr = 0;
    ba_ack = 0; ba_dst = 0; ba_rdy = 0;
  endtask

  // random-phase state: requesters, bank and the reference model
  logic [AW-1:0] r_addr [2];
  logic [15:0]   r_din  [2];
  logic [1:0]    r_m    [2];
  bit            held   [2];
  bit            active [2];
  bit            is_wr  [2];
  bit            b_acked;
  int            m_grantee;   // -1 none, else requester being served
  int            m_last;      // last grantee
  int            m_waits;     // game grants given while aux waited
  int            nx;

  // winner for an idle cycle, from the sharing rules
  function automatic int pick_winner(input bit want0, input bit want1, input int waits);
    if (want1 && waits >= STARVE) return 1;
    if (want0) return 0;
    if (want1) return 1;
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, grants0, k;
    bit aux_seen, prev_busy;

    rst = 1'b1;
    idle_inputs();
    rq0_addr = A0; rq1_addr = A1;
    rq0_din = 16'h1234; rq1_din = 16'habcd;
    rq0_din_m = 2'b01; rq1_din_m = 2'b10;

    vt[0]  = '{7'b1000000, 4'b0000, 3'b000, 3'b000};
    vt[1]  = '{7'b1000000, 4'b1001, 3'b000, 3'b000};
    vt[2]  = '{7'b1000000, 4'b1001, 3'b000, 3'b000};
    vt[3]  = '{7'b1000100, 4'b1001, 3'b100, 3'b000};
    vt[4]  = '{7'b0000010, 4'b0001, 3'b010, 3'b000};
    vt[5]  = '{7'b0000010, 4'b0001, 3'b010, 3'b000};
    vt[6]  = '{7'b0000011, 4'b0001, 3'b011, 3'b000};
    vt[7]  = '{7'b0000000, 4'b0000, 3'b000, 3'b000};
    vt[8]  = '{7'b1001000, 4'b0000, 3'b000, 3'b000};
    vt[9]  = '{7'b1001000, 4'b1001, 3'b000, 3'b000};
    vt[10] = '{7'b1001100, 4'b1001, 3'b100, 3'b000};
    vt[11] = '{7'b0001001, 4'b0001, 3'b001, 3'b000};
    vt[12] = '{7'b0001000, 4'b0000, 3'b000, 3'b000};
    vt[13] = '{7'b0001000, 4'b0111, 3'b000, 3'b000};
    vt[14] = '{7'b0001100, 4'b0111, 3'b000, 3'b100};
    vt[15] = '{7'b0000010, 4'b0011, 3'b000, 3'b010};
    vt[16] = '{7'b0000001, 4'b0011, 3'b000, 3'b001};
    vt[17] = '{7'b0000000, 4'b0010, 3'b000, 3'b000};

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_ba_rdwr", 32'({ba_rd, ba_wr}), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // game-only transfer, then simultaneous request (game first, aux after gap)
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      {rq0_rd, rq0_wr, rq1_rd, rq1_wr, ba_ack, ba_dst, ba_rdy} = vt[i].in;
      #1;
      chk($sformatf("vec%0d_rd_wr_own_busy", i), 32'({ba_rd, ba_wr, owner, busy}), 32'(vt[i].eo));
      chk($sformatf("vec%0d_rq0_hs", i), 32'({rq0_ack, rq0_dst, rq0_rdy}), 32'(vt[i].e0));
      chk($sformatf("vec%0d_rq1_hs", i), 32'({rq1_ack, rq1_dst, rq1_rdy}), 32'(vt[i].e1));
      chk($sformatf("vec%0d_addr", i), 32'(ba_addr), vt[i].eo[1] ? 32'(A1) : 32'(A0));
      chk($sformatf("vec%0d_din", i), 32'(ba_din), vt[i].eo[1] ? 32'h0000abcd : 32'h00001234);
      $display("vec %0d: in=%b out=%b%b%b%b", i, vt[i].in, ba_rd, ba_wr, owner, busy);
    end

    // starvation: aux held, game back-to-back; bank answers in one cycle
    @(negedge clk);
    idle_inputs();
    rq0_rd = 1; rq1_rd = 1;
    grants0 = 0; aux_seen = 0; prev_busy = 0;
    for (int c = 0; c < 200 && !aux_seen; c++) begin
      @(negedge clk);
      ba_ack = 0; ba_rdy = 0;
      #1;
      if (busy && !prev_busy) begin
        if (owner) begin
          aux_seen = 1;
          chk("starve_aux_addr", 32'(ba_addr), 32'(A1));
          chk("starve_aux_rd", 32'(ba_rd), 32'd1);
        end else begin
          grants0++;
        end
      end
      prev_busy = busy;
      if (busy) begin ba_ack = 1; ba_rdy = 1; end
    end
    chk("starve_aux_seen", 32'(aux_seen), 32'd1);
    chk("starve_game_grants", 32'(grants0), 32'(STARVE));
    $display("starve: %0d game grants before aux", grants0);
    @(negedge clk);
    idle_inputs();

    // routing isolation: dst toggles during an aux transfer
    @(negedge clk);
    rq1_rd = 1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ba_ack = (i == 0);
      rq1_rd = (i == 0);
      ba_dst = (i == 1 || i == 3 || i == 5 || i == 7);
      ba_rdy = (i == 9);
      #1;
      n1 += int'(rq1_dst);
      n0 += int'(rq0_dst | rq0_ack | rq0_rdy);
    end
    chk("iso_rq1_dst_pulses", 32'(n1), 32'd4);
    chk("iso_rq0_quiet", 32'(n0), 32'd0);
    $display("iso: rq1_dst pulses=%0d rq0 strobes=%0d", n1, n0);

    // async reset in the middle of a game transfer, aux pending
    @(negedge clk);
    idle_inputs();
    rq0_rd = 1;
    @(negedge clk);
    rq1_rd = 1;
    #1;
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ba_rd", 32'(ba_rd), 32'd0);
    chk("rstmid_owner", 32'(owner), 32'd0);
    @(negedge clk);
    rst = 1'b0; rq0_rd = 0;
    #1;
    chk("rstmid_idle_after", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    chk("rstmid_aux_grant", 32'({busy, owner, ba_rd}), 32'b111);
    ba_ack = 1; ba_rdy = 1; rq1_rd = 0;
    $display("rstmid: aux granted after reset release");
    @(negedge clk);
    idle_inputs();

`ifdef JTFRAME_SHARE_TIMEOUT_EN
    // watchdog: aux write never completes
    @(negedge clk);
    rq1_wr = 1;
    for (k = 0; k < 1024; k++) begin
      @(negedge clk);
      #1;
      if (k == 0)    chk("tmo_first_cycle", 32'({ba_wr, owner, busy}), 32'b111);
      if (k == 1022) chk("tmo_before", 32'({ba_wr, busy, timeout}), 32'b110);
      if (k == 1023) chk("tmo_fire_cycle", 32'({ba_wr, busy, timeout}), 32'b010);
    end
    @(negedge clk);
    rq1_wr = 0; rq0_rd = 1;
    #1;
    chk("tmo_idle", 32'({busy, timeout}), 32'b01);
    @(negedge clk);
    #1;
    chk("tmo_game_grant", 32'({busy, owner, ba_rd, timeout}), 32'b1011);
    ba_ack = 1; ba_rdy = 1; rq0_rd = 0;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("tmo_sticky", 32'(timeout), 32'd1);
    $display("timeout: watchdog fired after %0d busy cycles", k - 1);
`else
    k = 0;
    chk("timeout_tied_low", 32'(timeout), 32'd0);
`endif

    // random traffic against the model, from a fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_grantee = -1; m_last = 0; m_waits = 0; b_acked = 0; nx = 0;
    for (int r = 0; r < 2; r++) begin
      held[r] = 0; active[r] = 0; is_wr[r] = 0;
      r_addr[r] = '0; r_din[r] = '0; r_m[r] = '0;
    end
    for (int c = 0; c < 2000; c++) begin
      int sel, w;
      bit e_busy;
      logic [2:0] hs, e_hs0, e_hs1;
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!active[r] && ($urandom_range(0, 3) < (r == 0 ? 3 : 1))) begin
          active[r] = 1; held[r] = 1;
          is_wr[r]  = 1'($urandom_range(0, 1));
          r_addr[r] = AW'($urandom);
          r_din[r]  = 16'($urandom);
          r_m[r]    = 2'($urandom);
        end
      end
      rq0_rd = held[0] && !is_wr[0]; rq0_wr = held[0] && is_wr[0];
      rq1_rd = held[1] && !is_wr[1]; rq1_wr = held[1] && is_wr[1];
      rq0_addr = r_addr[0]; rq0_din = r_din[0]; rq0_din_m = r_m[0];
      rq1_addr = r_addr[1]; rq1_din = r_din[1]; rq1_din_m = r_m[1];
      ba_ack = 0; ba_dst = 0; ba_rdy = 0;
      if (m_grantee >= 0) begin
        if (!b_acked && $urandom_range(0, 2) == 0) ba_ack = 1;
        if (b_acked || ba_ack) begin
          ba_dst = 1'($urandom_range(0, 1));
          ba_rdy = ($urandom_range(0, 2) == 0);
        end
      end
      #1;
      e_busy = (m_grantee >= 0);
      sel = m_last;
      hs = {ba_ack, ba_dst, ba_rdy};
      e_hs0 = (m_grantee == 0) ? hs : 3'b000;
      e_hs1 = (m_grantee == 1) ? hs : 3'b000;
      chk("rnd_busy_owner", 32'({busy, owner}), 32'({e_busy, sel[0]}));
      chk("rnd_ba_rd", 32'(ba_rd), 32'(e_busy && held[sel] && !is_wr[sel]));
      chk("rnd_ba_wr", 32'(ba_wr), 32'(e_busy && held[sel] && is_wr[sel]));
      chk("rnd_ba_addr", 32'(ba_addr), 32'(r_addr[sel]));
      chk("rnd_ba_din", 32'({ba_din_m, ba_din}), 32'({r_m[sel], r_din[sel]}));
      chk("rnd_rq0_hs", 32'({rq0_ack, rq0_dst, rq0_rdy}), 32'(e_hs0));
      chk("rnd_rq1_hs", 32'({rq1_ack, rq1_dst, rq1_rdy}), 32'(e_hs1));
      // advance the model to the next edge
      if (m_grantee < 0) begin
        w = pick_winner(held[0], held[1], m_waits);
        if (w >= 0) begin
          if (w == 1) m_waits = 0;
          else if (held[1] && m_waits < 255) m_waits++;
          m_grantee = w; m_last = w;
        end
      end else if (ba_rdy) begin
        nx++;
        $display("xfer %0d: owner=%0d %s addr=%h", nx, m_grantee,
                 is_wr[m_grantee] ? "wr" : "rd", r_addr[m_grantee]);
        active[m_grantee] = 0;
        m_grantee = -1;
      end
      if (ba_ack && e_busy) held[sel] = 0;
      if (ba_rdy) b_acked = 0;
      else if (ba_ack) b_acked = 1;
    end
    chk("rnd_some_xfers", 32'(nx > 20), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
